mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_pkg.sv | 32 +++
 rtl/mmio_uart_tx_sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM encoding.
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; pointers carry one
// extra MSB so full and empty are distinguishable without a separate flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (TXDATA/STATUS/BAUDDIV) with a TX FIFO.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_access_addr,
    input  logic [15:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read,
    output logic [15:0] mem_read_data,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_off;
    logic          unused_addr0;
    logic          wr_txdata, wr_status, wr_bauddiv;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic [15:0]   status_word;

    tx_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   baud_div_q, baud_div_d;
    logic          bit_end;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign reg_off      = mem_access_addr[2:1];
    assign unused_addr0 = mem_access_addr[0];
    assign sel          = (mem_access_addr[15:3] == BASE_ADDR[15:3]) && (reg_off != 2'b11);
    assign wr_txdata    = mem_write_en && sel && (reg_off == OFF_TXDATA);
    assign wr_status    = mem_write_en && sel && (reg_off == OFF_STATUS);
    assign wr_bauddiv   = mem_write_en && sel && (reg_off == OFF_BAUDDIV);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (mem_write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status_word                          = '0;
        status_word[STAT_FULL]               = fifo_full;
        status_word[STAT_EMPTY]              = fifo_empty;
        status_word[STAT_BUSY]               = busy;
        status_word[STAT_OVERFLOW]           = overflow_q;
        status_word[STAT_COUNT_LSB +: CW]    = fifo_count;
    end

    always_comb begin
        mem_read_data = 16'h0000;
        if (mem_read && sel) begin
            case (reg_off)
                OFF_STATUS:  mem_read_data = status_word;
                OFF_BAUDDIV: mem_read_data = baud_div_q;
                default:     mem_read_data = 16'h0000;
            endcase
        end
    end

    // A drop and an explicit clear in the same cycle leave the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_txdata && fifo_full && !fifo_pop)
            overflow_d = 1'b1;
        else if (wr_status && mem_write_data[STAT_OVERFLOW])
            overflow_d = 1'b0;
        baud_div_d = wr_bauddiv ? mem_write_data : baud_div_q;
    end

    assign bit_end = (cnt_q == 16'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        // Reloading from the live divider only at bit boundaries keeps the
        // current bit length fixed while software rewrites BAUDDIV.
        if (state_q != ST_IDLE)
            cnt_d = bit_end ? baud_div_q : cnt_q - 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    cnt_d    = baud_div_q;
                    state_d  = ST_START;
`ifdef MMIO_UART_TX_PARITY_EN
                    parity_d = ^fifo_rd_data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = ST_START;
`ifdef MMIO_UART_TX_PARITY_EN
                        parity_d = ^fifo_rd_data;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line level is derived from the next state so it is registered.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            baud_div_q <= DEFAULT_DIV;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            baud_div_q <= baud_div_d;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level reference model compared
// every cycle, plus directed scenarios pinned with literal expectations.
module tb_mmio_uart_tx;

    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          FB    = 11;
`else
    localparam int          FB    = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        we = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] mem_read_data;
    logic        sel, tx, busy;

    int checks = 0;
    int failures = 0;

    // Reference model: byte queue plus the frame currently on the line.
    logic [7:0]  mq[$];
    bit          m_active;
    int          m_pos;
    int          m_left;
    logic [7:0]  m_byte;
    bit          m_ovf;
    logic [15:0] m_baud;

    logic        last_tx, last_busy, last_sel;
    logic [15:0] last_rdata;

    mmio_uart_tx dut (
        .clk             (clk),
        .reset           (reset),
        .mem_access_addr (addr),
        .mem_write_data  (wdata),
        .mem_write_en    (we),
        .mem_read        (rd),
        .mem_read_data   (mem_read_data),
        .sel             (sel),
        .tx              (tx),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic frame_level(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef MMIO_UART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic bit addr_sel(input logic [15:0] a);
        return (a[15:3] == BASE[15:3]) && (a[2:1] != 2'b11);
    endfunction

    function automatic logic [15:0] model_read();
        logic [15:0] s;
        if (!(rd && addr_sel(addr))) return 16'h0000;
        case (addr[2:1])
            2'd1: begin
                s = {4'h0, 4'(mq.size()), 4'h0, m_ovf, m_active,
                     (mq.size() == 0), (mq.size() == DEPTH)};
                return s;
            end
            2'd2:    return m_baud;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_pos    = 0;
        m_left   = 0;
        m_byte   = 8'h00;
        m_ovf    = 0;
        m_baud   = 16'd433;
    endtask

    // Advances the model across one rising edge using the pre-edge inputs.
    task automatic model_step();
        bit         s      = addr_sel(addr);
        bit         wr_tx  = we && s && (addr[2:1] == 2'd0);
        bit         wr_st  = we && s && (addr[2:1] == 2'd1);
        bit         wr_bd  = we && s && (addr[2:1] == 2'd2);
        int         sz0    = mq.size();
        bit         ending = m_active && (m_left == 1);
        bit         do_pop = (sz0 > 0) && (!m_active || (ending && m_pos == FB-1));
        bit         ovf_set = 0;
        logic [7:0] pb = 8'h00;
        if (do_pop) pb = mq.pop_front();
        if (wr_tx) begin
            if (sz0 < DEPTH || do_pop) mq.push_back(wdata[7:0]);
            else ovf_set = 1;
        end
        if (!m_active) begin
            if (do_pop) begin
                m_active = 1; m_byte = pb; m_pos = 0; m_left = int'(m_baud) + 1;
            end
        end else if (ending) begin
            if (m_pos == FB-1) begin
                if (do_pop) begin
                    m_byte = pb; m_pos = 0; m_left = int'(m_baud) + 1;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_pos++;
                m_left = int'(m_baud) + 1;
            end
        end else begin
            m_left--;
        end
        if (ovf_set) m_ovf = 1;
        else if (wr_st && wdata[3]) m_ovf = 0;
        if (wr_bd) m_baud = wdata;
    endtask

    // One clock: compare at the falling edge, then let the edge happen.
    task automatic tick();
        logic exp_tx;
        @(negedge clk);
        last_tx    = tx;
        last_busy  = busy;
        last_sel   = sel;
        last_rdata = mem_read_data;
        exp_tx = m_active ? frame_level(m_byte, m_pos) : 1'b1;
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("busy", 32'(busy), 32'(m_active));
        chk("sel", 32'(sel), 32'(addr_sel(addr)));
        chk("rdata", 32'(mem_read_data), 32'(model_read()));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1; rd = 1'b0;
        $display("store addr=%h data=%h", a, d);
        tick();
        we = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, output logic [15:0] d);
        addr = a; we = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = last_rdata;
        $display("load  addr=%h data=%h sel=%0b", a, d, last_sel);
    endtask

    task automatic idle(input int n);
        addr = 16'h0000; we = 1'b0; rd = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]     r;
        logic [FB-1:0]   got1, exp1;
        logic [2*FB-1:0] got2, exp2;
        int              busy_cnt;
        int              bound;

        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        idle(3);
        chk("reset_tx", 32'(last_tx), 32'd1);
        load(BASE + 16'd2, r);
        chk("reset_status", 32'(r), 32'h0002);
        load(BASE + 16'd4, r);
        chk("reset_bauddiv", 32'(r), 32'd433);

        // Single 0x55 frame at BAUDDIV=3
        store(BASE + 16'd4, 16'd3);
        store(BASE, 16'h0055);
`ifdef MMIO_UART_TX_PARITY_EN
        exp1 = 11'b01010101001;
`else
        exp1 = 10'b0101010101;
`endif
        got1 = '0;
        busy_cnt = 0;
        for (int k = 0; k < 4*FB + 10; k++) begin
            tick();
            if (last_busy) busy_cnt++;
            if (k >= 1 && ((k - 1) % 4) == 0 && ((k - 1) / 4) < FB)
                got1[FB-1-((k-1)/4)] = last_tx;
        end
        chk("frame55_bits", 32'(got1), 32'(exp1));
        chk("frame55_busy_len", 32'(busy_cnt), 32'(4*FB));

        // FIFO fill, overflow and clear
        store(BASE + 16'd4, 16'd15);
        for (int i = 0; i < 10; i++) store(BASE, 16'(i + 16'h10));
        load(BASE + 16'd2, r);
        chk("status_full_ovf", 32'(r), 32'h080D);
        store(BASE + 16'd2, 16'h0008);
        load(BASE + 16'd2, r);
        chk("status_ovf_clear", 32'(r), 32'h0805);
        idle(9 * 16 * FB + 20);

        // Back-to-back frames, no idle gap
        store(BASE + 16'd4, 16'd1);
        store(BASE, 16'h00A5);
        store(BASE, 16'h003C);
`ifdef MMIO_UART_TX_PARITY_EN
        exp2 = 22'b0101001010100011110001;
`else
        exp2 = 20'b01010010110001111001;
`endif
        got2 = '0;
        busy_cnt = 0;
        for (int k = 0; k < 4*FB + 6; k++) begin
            tick();
            if (last_busy) busy_cnt++;
            if ((k % 2) == 0 && (k / 2) < 2*FB) got2[2*FB-1-(k/2)] = last_tx;
        end
        chk("b2b_bits", 32'(got2), 32'(exp2));
        chk("b2b_busy_len", 32'(busy_cnt), 32'(4*FB));

        // Address decode and BAUDDIV readback
        load(BASE + 16'd6, r);
        chk("hole_rdata", 32'(r), 32'h0);
        chk("hole_sel", 32'(last_sel), 32'd0);
        load(16'h0010, r);
        chk("far_rdata", 32'(r), 32'h0);
        chk("far_sel", 32'(last_sel), 32'd0);
        store(BASE + 16'd4, 16'h1234);
        load(BASE + 16'd5, r);
        chk("bauddiv_rw", 32'(r), 32'h1234);
        store(BASE + 16'd4, 16'd2);

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            int op;
            op = $urandom_range(0, 99);
            we = 1'b0;
            rd = ($urandom_range(0, 2) == 0);
            addr = {(($urandom_range(0, 3) != 0) ? BASE[15:3] : 13'($urandom)), 3'($urandom)};
            wdata = 16'($urandom);
            if (op < 14) begin
                addr = BASE + 16'($urandom_range(0, 1));
                we = 1'b1;
            end else if (op < 18) begin
                addr = BASE + 16'd2;
                we = 1'b1;
            end else if (op < 20) begin
                addr = BASE + 16'd4;
                wdata = 16'($urandom_range(0, 4));
                we = 1'b1;
            end else if (op < 22) begin
                addr = BASE + 16'd6;
                we = 1'b1;
            end
            if (we) $display("store addr=%h data=%h (random)", addr, wdata);
            tick();
        end
        idle(1);
        bound = 0;
        while ((m_active || mq.size() != 0) && bound < 5000) begin
            tick();
            bound++;
        end
        chk("drain_bound", 32'(bound < 5000), 32'd1);

        // Asynchronous reset in the middle of a data bit
        store(BASE + 16'd4, 16'd3);
        for (int i = 0; i < 4; i++) store(BASE, 16'h0000);
        idle(8);
        chk("pre_reset_tx", 32'(last_tx), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", 32'(tx), 32'd1);
        chk("async_reset_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        load(BASE + 16'd2, r);
        chk("post_reset_status", 32'(r), 32'h0002);
        idle(100);
        chk("post_reset_idle_tx", 32'(last_tx), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
